mips_bus_arbiter: RTL
=====================

Name: mips_bus_arbiter

Overview:
- Parametrised bridge that merges the Harvard core's instruction and data ports onto one Avalon-MM master.
- Serialises requests through an arbitration FSM, honours waitrequest, and returns results on a valid pulse.
- Holds a single-word instruction cache so that repeated fetches of the same address skip the bus.
- Adds a waitrequest timeout with a sticky bus_error; sits between mips_cpu_harvard and the system memory bus.

Parameters:
- ADDR_W, 32, address width for both CPU ports and the Avalon port.
- DATA_W, 32, data width; must be a multiple of 8.
- BE_W, DATA_W/8, byteenable width.
- ARB_MODE, 0, 0 = fixed priority (data wins), 1 = round-robin (the last-served channel loses ties).
- TIMEOUT, 256, maximum consecutive waitrequest-high cycles per transfer; 0 disables the timeout.
- ICACHE_EN, 1, 1 = single-word instruction cache enabled.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the next rising edge of clk).
- instr_req  in  1  fetch request; a level held until instr_valid.
- instr_address  in  ADDR_W  fetch address; stable while instr_req is high.
- instr_readdata  out  DATA_W  fetched word; valid while instr_valid is high.
- instr_valid  out  1  one-cycle completion pulse.
- data_req  in  1  data request; a level held until data_valid.
- data_write  in  1  1 = write, 0 = read.
- data_address  in  ADDR_W  data address.
- data_writedata  in  DATA_W  write data.
- data_byteenable  in  BE_W  byte lanes.
- data_readdata  out  DATA_W  read result; valid with data_valid.
- data_valid  out  1  one-cycle completion pulse (reads and writes).
- cpu_stall  out  1  high while any asserted request has not yet received its valid pulse.
- bus_error  out  1  sticky timeout flag.
- address  out  ADDR_W  Avalon address.
- read  out  1  Avalon read.
- write  out  1  Avalon write.
- writedata  out  DATA_W  Avalon write data.
- byteenable  out  BE_W  Avalon byteenable (all ones for fetches).
- waitrequest  in  1  Avalon stall.
- readdata  in  DATA_W  Avalon read data; valid in the cycle where read=1 and waitrequest=0.

Behaviour:
- All outputs are registered.
- Reset values:
  - read, write, instr_valid, data_valid, bus_error: 0.
  - address, writedata, instr_readdata, data_readdata: 0.
  - byteenable: 0.
  - Cache is invalidated; round-robin pointer points at instr; FSM is in IDLE.
- cpu_stall is combinational from the req inputs and the pending state. It is 0 in reset.
- FSM states are IDLE, INSTR, DATA, HIT and ERROR.
- IDLE:
  - Selects a requester per ARB_MODE. Requests whose valid pulse is being issued this cycle are ignored.
  - Instr selected with ICACHE_EN and a cache hit (cache valid and tag == instr_address): go to HIT.
  - Otherwise go to INSTR or DATA, loading address, read/write, writedata and byteenable.
- INSTR / DATA:
  - Bus signals are held constant while waitrequest=1.
  - Completion occurs on a cycle with waitrequest=0. On that edge:
    - Capture readdata for reads.
    - Deassert read/write.
    - Pulse the matching valid in the next cycle.
    - Return to IDLE.
  - An INSTR completion loads cache tag and data and sets cache valid.
- HIT: instr_readdata is set from the cache, instr_valid pulses, and the FSM returns to IDLE. Latency from request to valid is 2 cycles.
- Bus latency: request in cycle 0, read/write in cycle 1, valid in cycle N+2, where N = number of waitrequest-high cycles.
- Cache invalidation: any completed data write whose address equals the cache tag invalidates the cache, regardless of byteenable.
- A request dropped mid-transfer still completes on the bus (Avalon transfers are not aborted). No valid pulse is issued.
- Simultaneous instr_req and data_req:
  - ARB_MODE 0: data is served first.
  - ARB_MODE 1: the channel not served last is served first.
- Timeout: a counter increments each INSTR/DATA cycle with waitrequest=1 and clears when a transfer completes. When it reaches TIMEOUT (TIMEOUT>0):
  - Deassert read/write.
  - Set bus_error.
  - Go to ERROR. ERROR ignores all requests, holds cpu_stall high while any req is high, and is left only by reset.
- Reset mid-transfer: read/write drop on the reset edge, and no valid pulse is issued.

Decomposition:
- Package mips_bus_pkg holds:
  - the arb_state_t enum (IDLE, INSTR, DATA, HIT, ERROR);
  - ARB_FIXED=0 and ARB_RR=1 constants;
  - the timeout counter width function $clog2(TIMEOUT+1).
- Sub-module mips_instr_word_cache holds the tag, data and valid registers, the hit compare, and load/invalidate. It is parametrised by ADDR_W/DATA_W.

Test Plan:
- Fetch 0xBFC00000, waitrequest=0, readdata=0x24020005 -> read=1 in cycle 1, instr_valid in cycle 2 with instr_readdata=0x24020005.
- Repeat the same fetch -> no read asserted, instr_valid after 2 cycles with the same data. Then a data write to 0xBFC00000, then a refetch -> bus read occurs.
- Simultaneous instr_req and data_req, ARB_MODE=0 -> data transfer first, instr transfer second. ARB_MODE=1, two rounds -> service alternates.
- Data write 0x1000, data 0xDEADBEEF, byteenable 4'b0011, waitrequest high for 3 cycles -> address/writedata/byteenable stable for 4 cycles, data_valid in cycle 5.
- TIMEOUT=4, waitrequest held high -> read drops, bus_error=1 after 4 wait cycles, later requests ignored. reset=0 for 1 cycle -> bus_error=0.
- reset=0 asserted during a pending read -> read=0 and no valid pulse on the next edge. After release, a fresh fetch completes normally.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the Harvard-to-Avalon bus arbiter.
package mips_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INSTR,
        DATA,
        HIT,
        ERROR
    } arb_state_t;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    // A disabled timeout still gets a 1-bit counter so widths stay legal.
    function automatic int unsigned timeout_cnt_w(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mips_instr_word_cache.sv
// Single-word instruction cache: one tag, one data word, one valid bit.
module mips_instr_word_cache #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              inval_i,
    input  logic [ADDR_W-1:0] inval_addr_i,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o
);

    logic [ADDR_W-1:0] tag_q, tag_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    always_comb begin
        tag_d   = tag_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            tag_d   = load_addr_i;
            data_d  = load_data_i;
            valid_d = 1'b1;
        end else if (inval_i && (inval_addr_i == tag_q)) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            tag_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            tag_q   <= tag_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign hit_o  = valid_q && (tag_q == lookup_addr_i);
    assign data_o = data_q;

endmodule

// File: rtl/mips_bus_arbiter.sv
// Merges the instruction and data ports of the Harvard core onto one
// Avalon-MM master, with a single-word fetch cache and a waitrequest timeout.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BE_W      = DATA_W / 8,
    parameter int unsigned ARB_MODE  = 0,
    parameter int unsigned TIMEOUT   = 256,
    parameter int unsigned ICACHE_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_req,
    input  logic [ADDR_W-1:0] instr_address,
    output logic [DATA_W-1:0] instr_readdata,
    output logic              instr_valid,
    input  logic              data_req,
    input  logic              data_write,
    input  logic [ADDR_W-1:0] data_address,
    input  logic [DATA_W-1:0] data_writedata,
    input  logic [BE_W-1:0]   data_byteenable,
    output logic [DATA_W-1:0] data_readdata,
    output logic              data_valid,
    output logic              cpu_stall,
    output logic              bus_error,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic [BE_W-1:0]   byteenable,
    input  logic              waitrequest,
    input  logic [DATA_W-1:0] readdata
);

    localparam int unsigned     CNT_W    = timeout_cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] writedata_q, writedata_d;
    logic [BE_W-1:0]   byteenable_q, byteenable_d;
    logic [DATA_W-1:0] ird_q, ird_d;
    logic              ivalid_q, ivalid_d;
    logic [DATA_W-1:0] drd_q, drd_d;
    logic              dvalid_q, dvalid_d;
    logic              berr_q, berr_d;
    logic              prio_instr_q, prio_instr_d;
    logic [CNT_W-1:0]  tcnt_q, tcnt_d;

    logic              instr_elig, data_elig, pick_instr;
    logic              cache_hit, cache_load, cache_inval;
    logic [DATA_W-1:0] cache_data;

    mips_instr_word_cache #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_icache (
        .clk          (clk),
        .rst_ni       (reset),
        .load_i       (cache_load),
        .load_addr_i  (address_q),
        .load_data_i  (readdata),
        .inval_i      (cache_inval),
        .inval_addr_i (address_q),
        .lookup_addr_i(instr_address),
        .hit_o        (cache_hit),
        .data_o       (cache_data)
    );

    // A request whose valid pulse is going out this cycle is already served.
    assign instr_elig = instr_req && !ivalid_q;
    assign data_elig  = data_req && !dvalid_q;
    assign pick_instr = instr_elig && (!data_elig || ((ARB_MODE == ARB_RR) && prio_instr_q));

    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        read_d       = read_q;
        write_d      = write_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        ird_d        = ird_q;
        ivalid_d     = 1'b0;
        drd_d        = drd_q;
        dvalid_d     = 1'b0;
        berr_d       = berr_q;
        prio_instr_d = prio_instr_q;
        tcnt_d       = tcnt_q;
        cache_load   = 1'b0;
        cache_inval  = 1'b0;

        case (state_q)
            IDLE: begin
                tcnt_d = '0;
                if (pick_instr) begin
                    prio_instr_d = 1'b0;
                    if ((ICACHE_EN != 0) && cache_hit) begin
                        state_d = HIT;
                    end else begin
                        state_d      = INSTR;
                        address_d    = instr_address;
                        read_d       = 1'b1;
                        write_d      = 1'b0;
                        byteenable_d = '1;
                    end
                end else if (data_elig) begin
                    prio_instr_d = 1'b1;
                    state_d      = DATA;
                    address_d    = data_address;
                    read_d       = !data_write;
                    write_d      = data_write;
                    writedata_d  = data_writedata;
                    byteenable_d = data_byteenable;
                end
            end

            INSTR, DATA: begin
                if (!waitrequest) begin
                    // The bus transfer always finishes; the pulse only goes to a live request.
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    tcnt_d  = '0;
                    state_d = IDLE;
                    if (state_q == INSTR) begin
                        ird_d      = readdata;
                        ivalid_d   = instr_req;
                        cache_load = 1'b1;
                    end else begin
                        if (read_q) begin
                            drd_d = readdata;
                        end
                        dvalid_d    = data_req;
                        cache_inval = write_q;
                    end
                end else if ((TIMEOUT != 0) && (tcnt_q == TMO_LAST)) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    berr_d  = 1'b1;
                    state_d = ERROR;
                end else begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                end
            end

            HIT: begin
                ird_d    = cache_data;
                ivalid_d = instr_req;
                state_d  = IDLE;
            end

            ERROR: begin
                state_d = ERROR;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            address_q    <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            writedata_q  <= '0;
            byteenable_q <= '0;
            ird_q        <= '0;
            ivalid_q     <= 1'b0;
            drd_q        <= '0;
            dvalid_q     <= 1'b0;
            berr_q       <= 1'b0;
            prio_instr_q <= 1'b1;
            tcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            read_q       <= read_d;
            write_q      <= write_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            ird_q        <= ird_d;
            ivalid_q     <= ivalid_d;
            drd_q        <= drd_d;
            dvalid_q     <= dvalid_d;
            berr_q       <= berr_d;
            prio_instr_q <= prio_instr_d;
            tcnt_q       <= tcnt_d;
        end
    end

    assign cpu_stall      = reset && ((instr_req && !ivalid_q) || (data_req && !dvalid_q));
    assign instr_readdata = ird_q;
    assign instr_valid    = ivalid_q;
    assign data_readdata  = drd_q;
    assign data_valid     = dvalid_q;
    assign bus_error      = berr_q;
    assign address        = address_q;
    assign read           = read_q;
    assign write          = write_q;
    assign writedata      = writedata_q;
    assign byteenable     = byteenable_q;

endmodule
